// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b types for the pipeline: opcode encoding, decoded control word
// and the occupancy state of a flow-controlled stage register.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    // Decoded control word travelling with each instruction (30 bits).
    typedef struct packed {
        lc3b_opcode  opcode;
        logic [2:0]  aluop;
        logic        load_regfile;
        logic        load_cc;
        logic        load_mar;
        logic        load_mdr;
        logic [1:0]  pcmux_sel;
        logic [1:0]  alumux_sel;
        logic [1:0]  regfilemux_sel;
        logic [1:0]  marmux_sel;
        logic        mdrmux_sel;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_byte_enable;
        logic [2:0]  dest;
        logic [2:0]  sr1;
    } ctrl_struct;

    localparam int LC3B_WORD_W = 16;

    function automatic logic [1:0] stage_occupancy(input stage_state_t s);
        case (s)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_pipe_stage_payload_reg.sv
// Width-parametrised payload register with load enable and synchronous
// active-low clear; holds one concatenated pipeline beat.
module stage_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// Generic valid/ready pipeline stage (PC, IR, operands, control) with an
// optional 2-entry skid buffer and a bubble-injecting flush.
//
// state | meaning
// EMPTY | nothing held, out_valid=0
// ONE   | main entry valid
// FULL  | main + skid valid, upstream stalled (SKID=1 only)
module id_ex_pipe_stage
    import lc3b_types::*;
#(
    parameter int                DATA_W   = LC3B_WORD_W,
    parameter int                NUM_OPS  = 2,
    parameter int                CTRL_W   = $bits(ctrl_struct),
    parameter bit                SKID     = 1'b1,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_pc,
    input  logic [DATA_W-1:0]         in_ir,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    input  logic [CTRL_W-1:0]         in_ctrl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_pc,
    output logic [DATA_W-1:0]         out_ir,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [CTRL_W-1:0]         out_ctrl,
    output lc3b_opcode                out_opcode,
    output logic [1:0]                occupancy
);

    localparam int OPS_W = NUM_OPS * DATA_W;
    localparam int PAY_W = 2 * DATA_W + OPS_W + CTRL_W;

    stage_state_t     r_state;
    stage_state_t     w_state_nxt;
    logic             r_in_ready;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_out_valid;
    logic             w_main_load;
    logic             w_skid_load;
    logic             w_main_sel_skid;
    logic [PAY_W-1:0] w_in_payload;
    logic [PAY_W-1:0] w_main_d;
    logic [PAY_W-1:0] w_main_q;
    logic [PAY_W-1:0] w_skid_q;

    assign w_in_payload = {in_pc, in_ir, in_ops, in_ctrl};
    assign w_in_fire    = in_valid & w_in_ready;
    assign w_out_fire   = w_out_valid & out_ready;

    // in_ready is registered from the next state so it never depends on out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_main_load     = 1'b0;
        w_skid_load     = 1'b0;
        w_main_sel_skid = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ONE;
                        w_main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_load = 1'b1;
                    end else if (w_in_fire && SKID) begin
                        w_state_nxt = FULL;
                        w_skid_load = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt     = ONE;
                        w_main_load     = 1'b1;
                        w_main_sel_skid = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        w_out_valid = 1'b0;
        occupancy   = stage_occupancy(r_state);
        case (r_state)
            ONE:     w_out_valid = 1'b1;
            FULL:    w_out_valid = 1'b1;
            default: w_out_valid = 1'b0;
        endcase
    end

    assign w_main_d = w_main_sel_skid ? w_skid_q : w_in_payload;

    stage_payload_reg #(.W(PAY_W)) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    generate
        if (SKID) begin : g_skid
            stage_payload_reg #(.W(PAY_W)) u_skid (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_load (w_skid_load),
                .i_d    (w_in_payload),
                .o_q    (w_skid_q)
            );
            assign w_in_ready = r_in_ready & rst_n;
        end else begin : g_noskid
            assign w_skid_q   = '0;
            assign w_in_ready = out_ready | ~w_out_valid;
        end
    endgenerate

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_pc     = w_main_q[CTRL_W + OPS_W + DATA_W +: DATA_W];
    assign out_ir     = w_main_q[CTRL_W + OPS_W +: DATA_W];
    assign out_ops    = w_main_q[CTRL_W +: OPS_W];
    assign out_ctrl   = w_out_valid ? w_main_q[CTRL_W-1:0] : CTRL_NOP;
    assign out_opcode = lc3b_opcode'(out_ir[DATA_W-1 -: 4]);

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed bench for id_ex_pipe_stage: a SKID=1 instance (a_*) and a SKID=0
// instance (b_*) sharing clock and reset.
module tb_id_ex_pipe_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_vec = 0;
    int          n_err = 0;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_in_pc, a_in_ir, a_out_pc, a_out_ir;
    logic [31:0] a_in_ops, a_out_ops;
    logic [29:0] a_in_ctrl, a_out_ctrl;
    logic [3:0]  a_opcode;
    logic [1:0]  a_occ;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_pc, b_in_ir, b_out_pc, b_out_ir;
    logic [31:0] b_in_ops, b_out_ops;
    logic [29:0] b_in_ctrl, b_out_ctrl;
    logic [3:0]  b_opcode;
    logic [1:0]  b_occ;

    always #5 clk = ~clk;

    id_ex_pipe_stage #(.SKID(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_pc(a_in_pc), .in_ir(a_in_ir), .in_ops(a_in_ops), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_pc(a_out_pc), .out_ir(a_out_ir), .out_ops(a_out_ops), .out_ctrl(a_out_ctrl),
        .out_opcode(a_opcode), .occupancy(a_occ)
    );

    id_ex_pipe_stage #(.SKID(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_pc(b_in_pc), .in_ir(b_in_ir), .in_ops(b_in_ops), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pc(b_out_pc), .out_ir(b_out_ir), .out_ops(b_out_ops), .out_ctrl(b_out_ctrl),
        .out_opcode(b_opcode), .occupancy(b_occ)
    );

    function automatic logic [31:0] exp_ops(input logic [15:0] pc);
        return {pc ^ 16'h00FF, pc ^ 16'hFF00};
    endfunction

    function automatic logic [29:0] exp_ctrl(input logic [15:0] pc);
        return {14'h1555, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [15:0] pc, input logic [15:0] ir);
        a_in_valid = v;
        a_in_pc    = pc;
        a_in_ir    = ir;
        a_in_ops   = exp_ops(pc);
        a_in_ctrl  = exp_ctrl(pc);
    endtask

    task automatic drive_b(input logic v, input logic [15:0] pc, input logic [15:0] ir);
        b_in_valid = v;
        b_in_pc    = pc;
        b_in_ir    = ir;
        b_in_ops   = exp_ops(pc);
        b_in_ctrl  = exp_ctrl(pc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_flush = 1'b0; a_out_ready = 1'b1; drive_a(1'b1, 16'h1111, 16'h1234);
        b_flush = 1'b0; b_out_ready = 1'b1; drive_b(1'b1, 16'h2222, 16'h5678);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
            n_vec++; if (a_out_ctrl !== 30'h0) begin n_err++; $display("FAIL reset_out_ctrl: got %h expected 0", a_out_ctrl); end
            n_vec++; if (a_occ !== 2'd0) begin n_err++; $display("FAIL reset_occupancy: got %0d expected 0", a_occ); end
            n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_low: got %b expected 0", a_in_ready); end
            n_vec++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_out_valid: got %b expected 0", b_out_valid); end
        end
        rst_n = 1'b1;
        drive_a(1'b0, 16'h0, 16'h0);
        drive_b(1'b0, 16'h0, 16'h0);
        tick();
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready: got %b expected 1", a_in_ready); end
        n_vec++; if (a_occ !== 2'd0) begin n_err++; $display("FAIL reset_release_occ: got %0d expected 0", a_occ); end
    endtask

    task automatic test_streaming();
        logic [15:0] irs [4];
        logic [15:0] pc;
        irs[0] = 16'h1042; irs[1] = 16'h5123; irs[2] = 16'h9FFF; irs[3] = 16'hE001;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 16'h3000 + 16'(i);
            drive_a(1'b1, pc, irs[i]);
            tick();
            n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, a_out_valid); end
            n_vec++; if (a_out_pc !== pc) begin n_err++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, a_out_pc, pc); end
            n_vec++; if (a_out_ir !== irs[i]) begin n_err++; $display("FAIL stream_ir[%0d]: got %h expected %h", i, a_out_ir, irs[i]); end
            n_vec++; if (a_opcode !== irs[i][15:12]) begin n_err++; $display("FAIL stream_opcode[%0d]: got %h expected %h", i, a_opcode, irs[i][15:12]); end
            n_vec++; if (a_out_ops !== exp_ops(pc)) begin n_err++; $display("FAIL stream_ops[%0d]: got %h expected %h", i, a_out_ops, exp_ops(pc)); end
            n_vec++; if (a_out_ctrl !== exp_ctrl(pc)) begin n_err++; $display("FAIL stream_ctrl[%0d]: got %h expected %h", i, a_out_ctrl, exp_ctrl(pc)); end
            n_vec++; if (a_in_ready !== 1'b1 || a_occ !== 2'd1) begin n_err++; $display("FAIL stream_ready_occ[%0d]: got %b/%0d expected 1/1", i, a_in_ready, a_occ); end
        end
        drive_a(1'b0, 16'h0, 16'h0);
        tick();
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid: got %b expected 0", a_out_valid); end
        n_vec++; if (a_out_ctrl !== 30'h0) begin n_err++; $display("FAIL stream_drain_ctrl_nop: got %h expected 0", a_out_ctrl); end
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b0;
        drive_a(1'b1, 16'h3000, 16'h1000);
        tick();
        n_vec++; if (a_out_pc !== 16'h3000 || a_occ !== 2'd1) begin n_err++; $display("FAIL bp_first: got pc %h occ %0d expected 3000/1", a_out_pc, a_occ); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_first_ready: got %b expected 1", a_in_ready); end
        drive_a(1'b1, 16'h3002, 16'h2000);
        tick();
        n_vec++; if (a_occ !== 2'd2) begin n_err++; $display("FAIL bp_full_occ: got %0d expected 2", a_occ); end
        n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b expected 0", a_in_ready); end
        n_vec++; if (a_out_pc !== 16'h3000) begin n_err++; $display("FAIL bp_full_pc: got %h expected 3000", a_out_pc); end
        drive_a(1'b1, 16'h3004, 16'h3000);
        tick();
        n_vec++; if (a_out_pc !== 16'h3000 || a_out_ctrl !== exp_ctrl(16'h3000) || a_occ !== 2'd2) begin n_err++; $display("FAIL bp_stable: got pc %h ctrl %h occ %0d expected 3000/%h/2", a_out_pc, a_out_ctrl, a_occ, exp_ctrl(16'h3000)); end
        a_out_ready = 1'b1;
        tick();
        n_vec++; if (a_out_pc !== 16'h3002 || a_out_ir !== 16'h2000 || a_occ !== 2'd1) begin n_err++; $display("FAIL bp_drain1: got pc %h ir %h occ %0d expected 3002/2000/1", a_out_pc, a_out_ir, a_occ); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_drain1_ready: got %b expected 1", a_in_ready); end
        tick();
        n_vec++; if (a_out_pc !== 16'h3004 || a_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_drain2: got pc %h valid %b expected 3004/1", a_out_pc, a_out_valid); end
        drive_a(1'b0, 16'h0, 16'h0);
        tick();
        n_vec++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin n_err++; $display("FAIL bp_empty: got valid %b occ %0d expected 0/0", a_out_valid, a_occ); end
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0;
        drive_a(1'b1, 16'h3100, 16'h6000);
        tick();
        drive_a(1'b1, 16'h3102, 16'h7000);
        tick();
        n_vec++; if (a_occ !== 2'd2) begin n_err++; $display("FAIL flush_setup_occ: got %0d expected 2", a_occ); end
        a_flush = 1'b1;
        drive_a(1'b1, 16'h4000, 16'hF025);
        tick();
        a_flush = 1'b0;
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b expected 0", a_out_valid); end
        n_vec++; if (a_out_ctrl !== 30'h0) begin n_err++; $display("FAIL flush_ctrl: got %h expected 0", a_out_ctrl); end
        n_vec++; if (a_occ !== 2'd0 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_occ_ready: got %0d/%b expected 0/1", a_occ, a_in_ready); end
        drive_a(1'b0, 16'h0, 16'h0);
        a_out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_ghost[%0d]: got valid %b pc %h expected 0", c, a_out_valid, a_out_pc); end
        end
    endtask

    task automatic test_skid0();
        b_out_ready = 1'b0;
        drive_b(1'b1, 16'h5000, 16'h1111);
        #1;
        n_vec++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL s0_empty_ready: got %b expected 1", b_in_ready); end
        tick();
        n_vec++; if (b_out_valid !== 1'b1 || b_out_pc !== 16'h5000 || b_occ !== 2'd1) begin n_err++; $display("FAIL s0_load: got valid %b pc %h occ %0d expected 1/5000/1", b_out_valid, b_out_pc, b_occ); end
        n_vec++; if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL s0_stall_ready: got %b expected 0", b_in_ready); end
        drive_b(1'b1, 16'h5001, 16'h2222);
        tick();
        n_vec++; if (b_out_pc !== 16'h5000 || b_occ !== 2'd1) begin n_err++; $display("FAIL s0_hold: got pc %h occ %0d expected 5000/1", b_out_pc, b_occ); end
        b_out_ready = 1'b1;
        #1;
        n_vec++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL s0_comb_ready: got %b expected 1", b_in_ready); end
        tick();
        n_vec++; if (b_out_pc !== 16'h5001 || b_out_ir !== 16'h2222 || b_occ !== 2'd1) begin n_err++; $display("FAIL s0_replace: got pc %h ir %h occ %0d expected 5001/2222/1", b_out_pc, b_out_ir, b_occ); end
        drive_b(1'b0, 16'h0, 16'h0);
        tick();
        n_vec++; if (b_out_valid !== 1'b0 || b_out_ctrl !== 30'h0) begin n_err++; $display("FAIL s0_drain: got valid %b ctrl %h expected 0/0", b_out_valid, b_out_ctrl); end
    endtask

    task automatic test_reset_flush();
        a_out_ready = 1'b0;
        drive_a(1'b1, 16'h6000, 16'h1234);
        tick();
        n_vec++; if (a_occ !== 2'd1) begin n_err++; $display("FAIL rf_setup_occ: got %0d expected 1", a_occ); end
        rst_n = 1'b0;
        a_flush = 1'b1;
        a_out_ready = 1'b1;
        drive_a(1'b1, 16'h6001, 16'h5678);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 30'h0) begin n_err++; $display("FAIL rf_valid_ctrl[%0d]: got %b/%h expected 0/0", c, a_out_valid, a_out_ctrl); end
            n_vec++; if (a_occ !== 2'd0 || a_in_ready !== 1'b0) begin n_err++; $display("FAIL rf_occ_ready[%0d]: got %0d/%b expected 0/0", c, a_occ, a_in_ready); end
            n_vec++; if (a_out_pc !== 16'h0) begin n_err++; $display("FAIL rf_payload_clear[%0d]: got %h expected 0", c, a_out_pc); end
        end
        rst_n = 1'b1;
        a_flush = 1'b0;
        drive_a(1'b0, 16'h0, 16'h0);
        tick();
        n_vec++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin n_err++; $display("FAIL rf_release: got ready %b valid %b expected 1/0", a_in_ready, a_out_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_skid0();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
